// File: rtl/mul_div_param.sv
// Iterative radix-2 multiplier / restoring divider, one step per clock.
// Define MUL_DIV_SIGNED_EN to add the sgn port for two's-complement operands.
module mul_div_param #(
  parameter int unsigned W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             muordi,
`ifdef MUL_DIV_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [W-1:0]     opera1,
  input  logic [2*W-1:0]   opera2,
  output logic [2*W-1:0]   result,
  output logic             valid,
  output logic             busy,
  output logic             dz,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] CntInit = CW'(W);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opa_q, opa_d;
  logic           div_q, div_d;
  logic           sgn_q, sgn_d;
  logic           skip_q, skip_d;
  logic           dz_pend_q, dz_pend_d;
  logic           ovf_pend_q, ovf_pend_d;
  logic           neg_lo_q, neg_lo_d;
  logic           neg_hi_q, neg_hi_d;
  logic           armed_q;
  logic [2*W-1:0] result_q, result_d;
  logic           dz_q, dz_d;
  logic           ovf_q, ovf_d;

  logic           sgn_en;
  logic           accept;
  logic           finish;
  logic           a_neg, m_neg, d_neg;
  logic [W-1:0]   a_mag, m_mag;
  logic [2*W-1:0] d_mag;
  logic [W:0]     mul_sum;
  logic [W:0]     div_tmp, div_diff;
  logic [W-1:0]   quo_fix, rem_fix;

`ifdef MUL_DIV_SIGNED_EN
  assign sgn_en = sgn;
`else
  assign sgn_en = 1'b0;
`endif

  // Operand magnitudes; in unsigned mode these are the operands themselves.
  assign a_neg = sgn_en & opera1[W-1];
  assign m_neg = sgn_en & opera2[W-1];
  assign d_neg = sgn_en & opera2[2*W-1];
  assign a_mag = a_neg ? -opera1 : opera1;
  assign m_mag = m_neg ? -opera2[W-1:0] : opera2[W-1:0];
  assign d_mag = d_neg ? -opera2 : opera2;

  // armed_q blocks a start on the first edge after reset release.
  assign accept = start & armed_q & (state_q != StCalc);
  assign finish = (state_q == StCalc) & ((cnt_q == '0) | skip_q);

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign div_tmp  = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff = div_tmp - {1'b0, opa_q};
  assign quo_fix  = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  if (finish) state_d = StDone;
      StDone:  state_d = accept ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid  = (state_q == StDone);
    busy   = (state_q == StCalc);
    result = result_q;
    dz     = dz_q;
    ovf    = ovf_q;
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opa_d      = opa_q;
    div_d      = div_q;
    sgn_d      = sgn_q;
    skip_d     = skip_q;
    dz_pend_d  = dz_pend_q;
    ovf_pend_d = ovf_pend_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    result_d   = result_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    if (accept) begin
      cnt_d = CntInit;
      opa_d = a_mag;
      div_d = muordi;
      sgn_d = sgn_en;
      if (!muordi) begin
        acc_d      = {{W{1'b0}}, m_mag};
        neg_lo_d   = a_neg ^ m_neg;
        neg_hi_d   = 1'b0;
        dz_pend_d  = 1'b0;
        ovf_pend_d = 1'b0;
        skip_d     = 1'b0;
      end else begin
        dz_pend_d  = (opera1 == '0);
        ovf_pend_d = (opera1 != '0) & (d_mag[2*W-1:W] >= a_mag);
        // Dividend is kept raw for divide-by-zero: its low half is the remainder.
        acc_d      = (opera1 == '0) ? opera2 : d_mag;
        neg_lo_d   = a_neg ^ d_neg;
        neg_hi_d   = d_neg;
        // Signed overflow is reported at normal latency, so only unsigned skips.
        skip_d     = (opera1 == '0) | ((d_mag[2*W-1:W] >= a_mag) & ~sgn_en);
      end
    end else if (finish) begin
      dz_d  = 1'b0;
      ovf_d = 1'b0;
      if (!div_q) begin
        result_d = neg_lo_q ? -acc_q : acc_q;
      end else if (dz_pend_q) begin
        result_d = {acc_q[W-1:0], {W{1'b1}}};
        dz_d     = 1'b1;
      end else if (ovf_pend_q | (sgn_q & acc_q[W-1])) begin
        result_d = '1;
        ovf_d    = 1'b1;
      end else begin
        result_d = {rem_fix, quo_fix};
      end
    end else if (state_q == StCalc) begin
      cnt_d = cnt_q - 1'b1;
      if (!div_q) begin
        acc_d = {mul_sum, acc_q[W-1:1]};
      end else if (!div_diff[W]) begin
        acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        acc_d = {div_tmp[W-1:0], acc_q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opa_q      <= '0;
      div_q      <= 1'b0;
      sgn_q      <= 1'b0;
      skip_q     <= 1'b0;
      dz_pend_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      armed_q    <= 1'b0;
      result_q   <= '0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opa_q      <= opa_d;
      div_q      <= div_d;
      sgn_q      <= sgn_d;
      skip_q     <= skip_d;
      dz_pend_q  <= dz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      armed_q    <= 1'b1;
      result_q   <= result_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mul_div_param.sv
// Randomized self-checking bench for mul_div_param against an arithmetic reference model.
module tb_mul_div_param;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           muordi = 1'b0;
  logic           sgn = 1'b0;
  logic [W-1:0]   opera1 = '0;
  logic [2*W-1:0] opera2 = '0;
  logic [2*W-1:0] result;
  logic           valid, busy, dz, ovf;

  int n_vec = 0;
  int n_err = 0;

  mul_div_param #(.W(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .muordi (muordi),
`ifdef MUL_DIV_SIGNED_EN
    .sgn    (sgn),
`endif
    .opera1 (opera1),
    .opera2 (opera2),
    .result (result),
    .valid  (valid),
    .busy   (busy),
    .dz     (dz),
    .ovf    (ovf)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic md, input logic [W-1:0] a, input logic [2*W-1:0] b,
                                input logic s, output logic [2*W-1:0] r, output logic edz,
                                output logic eovf, output int lat);
    logic signed [2*W-1:0] sa, sb;
    logic [2*W-1:0] am, bm, q, rm;
    edz = 0; eovf = 0; lat = W + 1;
    if (!md) begin
      if (s) begin
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b[W-1:0]};
        r  = sa * sb;
      end else begin
        r = {{W{1'b0}}, a} * {{W{1'b0}}, b[W-1:0]};
      end
    end else if (a == 0) begin
      edz = 1; lat = 1;
      r = {b[W-1:0], {W{1'b1}}};
    end else if (!s) begin
      if (b[2*W-1:W] >= a) begin
        eovf = 1; lat = 1; r = '1;
      end else begin
        q = b / {{W{1'b0}}, a};
        rm = b % {{W{1'b0}}, a};
        r = {rm[W-1:0], q[W-1:0]};
      end
    end else begin
      sa = {{W{a[W-1]}}, a};
      sb = b;
      am = (sa < 0) ? -sa : sa;
      bm = (sb < 0) ? -sb : sb;
      q  = bm / am;
      rm = bm % am;
      if (q >= (64'd1 << (W - 1))) begin
        eovf = 1; r = '1;
      end else begin
        if (a[W-1] ^ b[2*W-1]) q = -q;
        if (b[2*W-1]) rm = -rm;
        r = {rm[W-1:0], q[W-1:0]};
      end
    end
  endfunction

  // Issues a start now (caller is #1 after a rising edge), checks latency and outputs.
  task automatic run_op(input string tag, input logic md, input logic [W-1:0] a,
                        input logic [2*W-1:0] b, input logic s, input bit poke, input bit gap);
    logic [2*W-1:0] er;
    logic edz, eovf;
    int lat, n;
    bit got;
    model(md, a, b, s, er, edz, eovf, lat);
    start = 1; muordi = md; opera1 = a; opera2 = b; sgn = s;
    @(posedge clock); #1;
    start = 0; opera1 = $urandom; opera2 = {$urandom, $urandom}; muordi = $urandom; sgn = $urandom;
    check({tag, ".busy"}, busy, 1);
    n = 0; got = 0;
    while (!got && n < W + 8) begin
      if (poke && n == 2 && lat > 3) start = 1;
      @(posedge clock); #1;
      start = 0; n++; got = valid;
    end
    check({tag, ".lat"}, n, lat);
    check({tag, ".res"}, result, er);
    check({tag, ".flags"}, {dz, ovf, busy}, {edz, eovf, 1'b0});
    if (gap) begin
      @(posedge clock); #1;
      check({tag, ".hold"}, {valid, busy, dz, ovf, result}, {1'b0, 1'b0, edz, eovf, er});
    end
  endtask

  initial begin
    logic [W-1:0] a, hi;
    logic [2*W-1:0] b;
    int kind;
    bit s;
    #1;
    check("rst.out", {result, valid, busy, dz, ovf}, '0);
    repeat (2) @(posedge clock);
    #1 reset = 0;
    repeat (2) @(posedge clock);
    #1;

    run_op("mul3x9", 0, 3, 64'd9, 0, 0, 1);
    run_op("div100_7", 1, 7, 64'd100, 0, 1, 1);
    run_op("divz", 1, 0, 64'h55, 0, 0, 0);
    run_op("divovf", 1, 3, 64'h00000005_00000000, 0, 0, 1);
    run_op("mulhi", 0, '1, {32'hDEADBEEF, 32'hFFFFFFFF}, 0, 0, 0);
`ifdef MUL_DIV_SIGNED_EN
    run_op("sdiv", 1, 2, -64'sd7, 1, 0, 1);
    run_op("smul", 0, -32'sd5, 64'd7, 1, 0, 1);
`endif

    // Reset in the middle of a multiply abandons it.
    start = 1; muordi = 0; opera1 = 3; opera2 = 9; sgn = 0;
    @(posedge clock); #1 start = 0;
    repeat (10) @(posedge clock);
    #1 reset = 1;
    #1 check("rstmid.out", {result, valid, busy, dz, ovf}, '0);
    repeat (3) begin
      @(posedge clock); #1;
      check("rstmid.novalid", valid, 0);
    end
    @(negedge clock) reset = 0;
    repeat (2) @(posedge clock);
    #1;
    run_op("mul3x9b", 0, 3, 64'd9, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
`ifdef MUL_DIV_SIGNED_EN
      s = $urandom;
`else
      s = 0;
`endif
      a = $urandom;
      if (a == 0) a = 1;
      b = {$urandom, $urandom};
      if (kind < 4) begin
        run_op("rmul", 0, a, b, s, $urandom, $urandom);
      end else if (kind < 8) begin
        hi = $urandom % a;
        run_op("rdiv", 1, a, {hi, b[W-1:0]}, s, $urandom, $urandom);
      end else if (kind == 8) begin
        run_op("rdivz", 1, 0, b, s, 0, $urandom);
      end else begin
        hi = a + $urandom_range(0, 100);
        if (hi < a) hi = a;
        run_op("rovf", 1, a, {hi, b[W-1:0]}, s, 0, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
